// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM encoding and idle line level.
package seq_pkg;

    // Two-state controller: waiting for a word, or shifting one out.
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    // Level driven on serial_bit while no word is being shifted.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage : seq_pkg

// File: rtl/seq_bit_serializer_if.sv
// Word-in / serial-out bundle between a word producer and the serializer.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
);
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             msb_first;
    logic [DIV_W-1:0] div;
    logic             serial_bit;
    logic             bit_strobe;
    logic             frame_done;
    logic             busy;

    // Producer side: offers words and timing settings, watches the serial line.
    modport master (
        output word_in, word_valid, msb_first, div,
        input  word_ready, serial_bit, bit_strobe, frame_done, busy
    );

    // Serializer side.
    modport slave (
        input  word_in, word_valid, msb_first, div,
        output word_ready, serial_bit, bit_strobe, frame_done, busy
    );
endinterface : seq_bit_serializer_if

// File: rtl/seq_bit_serializer_timer.sv
// Loadable bit-period down-counter. A period lasts period+1 cycles; the
// counter reloads itself at each period end while run is high. Both tick
// flags are registered so they can drive outputs directly.
module seq_bit_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,          // start a fresh period sequence
    input  logic             run,           // keep counting after this edge
    input  logic [DIV_W-1:0] period,        // cycles per period minus one
    output logic             tick_first,    // first cycle of a period
    output logic             tick_last,     // last cycle of a period
    output logic             tick_last_nxt  // tick_last value after next edge
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    // Next-state: load a new period, count down with auto-reload, or stop.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        cnt_d    = cnt_q;
        period_d = period_q;
        first_d  = 1'b0;
        last_d   = 1'b0;
        if (load) begin
            cnt_d    = period;
            period_d = period;
            first_d  = 1'b1;
            last_d   = (period == '0);
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d   = period_q;
                first_d = 1'b1;
                last_d  = (period_q == '0);
            end else begin
                cnt_d  = cnt_q - DIV_W'(1);
                last_d = (cnt_q == DIV_W'(1));
            end
        end
    end

    // Counter and tick flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            period_q <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            cnt_q    <= cnt_d;
            period_q <= period_d;
            first_q  <= first_d;
            last_q   <= last_d;
        end
    end

    assign tick_first    = first_q;
    assign tick_last     = last_q;
    assign tick_last_nxt = last_d;

endmodule : seq_bit_timer

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Words arrive over a
// valid/ready handshake, a one-word hold register lets the next word wait
// while the current one shifts, so consecutive words stream gap-free.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   DIV_W      = 8,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_bit_serializer_if.slave  bus
);
    localparam int BCW = $clog2(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             msb_q, msb_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             serial_q, serial_d;
    logic             frame_done_q, frame_done_d;

    logic             transfer;
    logic             word_end;
    logic             load_word;
    logic [WIDTH-1:0] load_src;
    logic             tick_first;
    logic             tick_last;
    logic             tick_last_nxt;

    // Handshake decode: ready depends only on the hold flop.
    assign transfer = bus.word_valid & ~hold_full_q;
    assign word_end = (state_q == SER_SHIFT) && tick_last
                      && (bit_cnt_q == BCW'(WIDTH - 1));

    // FSM next-state, shifter, hold register and registered output values.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        msb_d       = msb_q;
        bit_cnt_d   = bit_cnt_q;
        serial_d    = serial_q;
        load_word   = 1'b0;
        load_src    = bus.word_in;

        case (state_q)
            SER_IDLE: begin
                if (transfer) begin
                    load_word = 1'b1;
                end
            end
            SER_SHIFT: begin
                if (word_end) begin
                    if (hold_full_q) begin
                        load_word   = 1'b1;
                        load_src    = hold_q;
                        hold_full_d = 1'b0;
                    end else if (transfer) begin
                        load_word = 1'b1;
                    end else begin
                        state_d  = SER_IDLE;
                        serial_d = IDLE_LEVEL;
                    end
                end else begin
                    if (tick_last) begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        serial_d  = msb_q ? shift_q[WIDTH-1] : shift_q[0];
                        shift_d   = msb_q ? {shift_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shift_q[WIDTH-1:1]};
                    end
                    if (transfer) begin
                        hold_d      = bus.word_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase

        // A word load presents its first bit on the next cycle; bit order
        // and period are captured here and frozen for the whole word.
        if (load_word) begin
            state_d   = SER_SHIFT;
            msb_d     = bus.msb_first;
            bit_cnt_d = '0;
            serial_d  = bus.msb_first ? load_src[WIDTH-1] : load_src[0];
            shift_d   = bus.msb_first ? {load_src[WIDTH-2:0], 1'b0}
                                      : {1'b0, load_src[WIDTH-1:1]};
        end
    end

    // frame_done is computed one cycle early so the output comes from a flop.
    always_comb begin
        frame_done_d = (state_d == SER_SHIFT) && tick_last_nxt
                       && (bit_cnt_d == BCW'(WIDTH - 1));
    end

    // Bit-period timing.
    seq_bit_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .load          (load_word),
        .run           (state_d == SER_SHIFT),
        .period        (bus.div),
        .tick_first    (tick_first),
        .tick_last     (tick_last),
        .tick_last_nxt (tick_last_nxt)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shifter and hold data are reset along with control so
            // an aborted word leaves no stale bits behind.
            state_q      <= SER_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            msb_q        <= 1'b0;
            bit_cnt_q    <= '0;
            serial_q     <= IDLE_LEVEL;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            msb_q        <= msb_d;
            bit_cnt_q    <= bit_cnt_d;
            serial_q     <= serial_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.word_ready = ~hold_full_q;
    assign bus.serial_bit = serial_q;
    assign bus.bit_strobe = tick_first;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == SER_SHIFT);

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: reset abort, single words in both
// bit orders, divided rate, back-to-back streaming and mid-word setting changes.
module tb_seq_bit_serializer;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [15:0] cap;
    int   stb_cnt;
    int   fd_seen;

    seq_bit_serializer_if #(.WIDTH(8), .DIV_W(8)) bus ();

    seq_bit_serializer #(
        .WIDTH      (8),
        .DIV_W      (8),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one whole word starting in its first serial cycle; leaves the
    // bench in the cycle after the word. At cycle poke_at (after its edge)
    // word_valid drops and msb_first/div take the poke values.
    task automatic expect_word(input string tag, input logic [7:0] w, input logic m,
                               input int d, input int poke_at, input logic pm,
                               input logic [7:0] pd);
        int n;
        int idx;
        logic eb;
        n = (d + 1) * 8;
        for (int c = 0; c < n; c++) begin
            idx = c / (d + 1);
            eb  = m ? w[7 - idx] : w[idx];
            check($sformatf("%s serial c%0d", tag, c), bus.serial_bit, eb);
            check($sformatf("%s strobe c%0d", tag, c), bus.bit_strobe, (c % (d + 1)) == 0);
            check($sformatf("%s fdone c%0d", tag, c), bus.frame_done, c == n - 1);
            check($sformatf("%s busy c%0d", tag, c), bus.busy, 1'b1);
            if (bus.bit_strobe) begin
                cap = {cap[14:0], bus.serial_bit};
                stb_cnt++;
            end
            tick();
            if (c == poke_at) begin
                bus.word_valid = 1'b0;
                bus.msb_first  = pm;
                bus.div        = pd;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cap   = '0;
        stb_cnt = 0;
        fd_seen = 0;

        // Reset held with a word offered: handshake must be dropped.
        reset          = 1'b0;
        bus.word_in    = 8'hFF;
        bus.word_valid = 1'b1;
        bus.msb_first  = 1'b1;
        bus.div        = 8'd0;
        tick(); tick(); tick();
        check("rst serial", bus.serial_bit, 1'b0);
        check("rst busy", bus.busy, 1'b0);
        check("rst ready", bus.word_ready, 1'b1);
        check("rst strobe", bus.bit_strobe, 1'b0);
        check("rst fdone", bus.frame_done, 1'b0);
        bus.word_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("rst dropped busy", bus.busy, 1'b0);

        // 1. Reset mid-word: 0xA5 div=3 with 0x3C waiting in hold.
        bus.word_in    = 8'hA5;
        bus.word_valid = 1'b1;
        bus.msb_first  = 1'b1;
        bus.div        = 8'd3;
        tick();
        bus.word_in = 8'h3C;
        tick();
        bus.word_valid = 1'b0;
        check("abort hold full", bus.word_ready, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        check("abort busy before", bus.busy, 1'b1);
        check("abort strobe bit4", bus.bit_strobe, 1'b0);
        reset = 1'b0;
        #1;
        check("abort serial", bus.serial_bit, 1'b0);
        check("abort busy", bus.busy, 1'b0);
        check("abort ready", bus.word_ready, 1'b1);
        check("abort fdone", bus.frame_done, 1'b0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.frame_done) fd_seen++;
        end
        check("abort no fdone", fd_seen, 0);
        check("abort stays idle", bus.busy, 1'b0);

        // 2. 0xB2 MSB first, div=0.
        bus.word_in    = 8'hB2;
        bus.word_valid = 1'b1;
        bus.msb_first  = 1'b1;
        bus.div        = 8'd0;
        tick();
        bus.word_valid = 1'b0;
        stb_cnt = 0;
        expect_word("b2msb", 8'hB2, 1'b1, 0, -1, 1'b1, 8'd0);
        check("b2msb bits", cap[7:0], 8'hB2);
        check("b2msb strobes", stb_cnt, 8);
        check("b2msb idle busy", bus.busy, 1'b0);
        check("b2msb idle serial", bus.serial_bit, 1'b0);

        // 3. 0xB2 LSB first, div=2: bits 0,1,0,0,1,1,0,1.
        bus.word_valid = 1'b1;
        bus.msb_first  = 1'b0;
        bus.div        = 8'd2;
        tick();
        bus.word_valid = 1'b0;
        stb_cnt = 0;
        expect_word("b2lsb", 8'hB2, 1'b0, 2, -1, 1'b0, 8'd2);
        check("b2lsb bits", cap[7:0], 8'h4D);
        check("b2lsb strobes", stb_cnt, 8);
        check("b2lsb idle busy", bus.busy, 1'b0);

        // 4. Back-to-back 0xFF then 0x00, valid held, div=0.
        bus.word_in    = 8'hFF;
        bus.word_valid = 1'b1;
        bus.msb_first  = 1'b1;
        bus.div        = 8'd0;
        tick();
        bus.word_in = 8'h00;
        for (int c = 0; c < 17; c++) begin
            check($sformatf("b2b serial c%0d", c), bus.serial_bit, c < 8);
            check($sformatf("b2b busy c%0d", c), bus.busy, c < 16);
            check($sformatf("b2b strobe c%0d", c), bus.bit_strobe, c < 16);
            check($sformatf("b2b fdone c%0d", c), bus.frame_done, (c == 7) || (c == 15));
            check($sformatf("b2b ready c%0d", c), bus.word_ready, !((c >= 1) && (c <= 7)));
            tick();
            if (c == 0) bus.word_valid = 1'b0;
        end

        // 5. Settings changed mid-word only affect the next word.
        bus.word_in    = 8'h0F;
        bus.word_valid = 1'b1;
        bus.msb_first  = 1'b1;
        bus.div        = 8'd1;
        tick();
        bus.word_valid = 1'b0;
        expect_word("mid old", 8'h0F, 1'b1, 1, 4, 1'b0, 8'd0);
        check("mid old bits", cap[7:0], 8'h0F);
        check("mid old idle", bus.busy, 1'b0);
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        expect_word("mid new", 8'h0F, 1'b0, 0, -1, 1'b0, 8'd0);
        check("mid new bits", cap[7:0], 8'hF0);

        // 6. Stream 0x5A,0x5A at full rate: 16 contiguous bits.
        bus.word_in    = 8'h5A;
        bus.word_valid = 1'b1;
        bus.msb_first  = 1'b1;
        bus.div        = 8'd0;
        tick();
        stb_cnt = 0;
        expect_word("strm w0", 8'h5A, 1'b1, 0, 0, 1'b1, 8'd0);
        expect_word("strm w1", 8'h5A, 1'b1, 0, -1, 1'b1, 8'd0);
        check("strm bits", cap, 16'h5A5A);
        check("strm strobes", stb_cnt, 16);
        check("strm idle", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_bit_serializer
